// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the alu_mc ALU.
// The slave modport is the ALU side and the master modport is the requester side.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   modport slave (
      input  in_valid, op, op1, op2, out_ready,
      output in_ready, out_valid, result, busy
   );

   modport master (
      output in_valid, op, op1, op2, out_ready,
      input  in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU with a registered result.
// All operations except MUL complete in one cycle. MUL is a WIDTH-cycle
// shift-add iteration that is present only when ALU_MC_MUL_EN is defined.
// Without ALU_MC_MUL_EN, opcode 10 behaves as ADD, busy stays low and
// the EXEC state is never entered.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   // Single-cycle operations; MUL and the unused codes fall back to ADD.
   function automatic logic [WIDTH-1:0] alu_f(
      input logic [3:0]       f_op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [SHW-1:0] shamt;
      shamt = b[SHW-1:0];
      case (f_op)
         OP_ADD:  alu_f = a + b;
         OP_SUB:  alu_f = a - b;
         OP_AND:  alu_f = a & b;
         OP_OR:   alu_f = a | b;
         OP_XOR:  alu_f = a ^ b;
         OP_SLL:  alu_f = a << shamt;
         OP_SRL:  alu_f = a >> shamt;
         OP_SRA:  alu_f = $unsigned($signed(a) >>> shamt);
         OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_f = {{(WIDTH-1){1'b0}}, (a < b)};
         default: alu_f = a + b;
      endcase
   endfunction

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_s;
   logic             accept_s;

`ifdef ALU_MC_MUL_EN
   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
   localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};

   logic             busy_q,   busy_d;
   logic [SHW-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

   // A new operation may enter from IDLE, or from DONE while the result is consumed.
   always_comb begin
      if (state_q == ST_IDLE) begin
         in_ready_s = 1'b1;
      end else if (state_q == ST_DONE) begin
         in_ready_s = bus.out_ready;
      end else begin
         in_ready_s = 1'b0;
      end
      accept_s = bus.in_valid & in_ready_s;
   end

   // Next-state logic for the FSM, result register and multiplier datapath.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
`ifdef ALU_MC_MUL_EN
      busy_d      = busy_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
`ifdef ALU_MC_MUL_EN
               if (bus.op == OP_MUL) begin
                  state_d     = ST_EXEC;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b1;
                  cnt_d       = CNT_ZERO;
                  acc_d       = {WIDTH{1'b0}};
                  mcand_d     = bus.op1;
                  mplier_d    = bus.op2;
               end else begin
                  state_d     = ST_DONE;
                  result_d    = alu_f(bus.op, bus.op1, bus.op2);
                  out_valid_d = 1'b1;
               end
`else
               state_d     = ST_DONE;
               result_d    = alu_f(bus.op, bus.op1, bus.op2);
               out_valid_d = 1'b1;
`endif
            end else if ((state_q == ST_DONE) && bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_EXEC: begin
`ifdef ALU_MC_MUL_EN
            // One multiplier bit per cycle, LSB first.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end else begin
               acc_d = acc_q;
            end
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               result_d    = acc_d;
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
               cnt_d       = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
`else
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
`endif
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
         busy_q      <= 1'b0;
         cnt_q       <= {SHW{1'b0}};
         acc_q       <= {WIDTH{1'b0}};
         mcand_q     <= {WIDTH{1'b0}};
         mplier_q    <= {WIDTH{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
`ifdef ALU_MC_MUL_EN
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
`ifdef ALU_MC_MUL_EN
   assign bus.busy      = busy_q;
`else
   assign bus.busy      = 1'b0;
`endif

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port op  input  4  operation code, encoded as 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL.
REQ-007 SHALL have port op1  input  WIDTH  first operand.
REQ-008 SHALL have port op2  input  WIDTH  second operand.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  WIDTH  registered operation result.
REQ-012 SHALL have port busy  output  1  high while a multi-cycle operation is iterating.

Function
REQ-013 SHALL implement an FSM with states IDLE, EXEC and DONE.
REQ-014 SHALL drive in_ready high in IDLE, and in DONE when out_ready is high; it SHALL be low otherwise.
REQ-015 SHALL accept an operation on a rising edge where in_valid and in_ready are both high, capturing op, op1 and op2.
REQ-016 SHALL complete single-cycle ops (all except MUL) in one cycle: result registered at acceptance, out_valid high from the next cycle, next state DONE.
REQ-017 SHALL compute ADD, SUB, AND, OR and XOR modulo 2^WIDTH, with wrap-around and no overflow flag.
REQ-018 SHALL take the shift amount for SLL, SRL and SRA from op2[log2(WIDTH)-1:0], ignoring the upper bits; SRA SHALL sign-extend.
REQ-019 SHALL return 1 for SLT when op1 < op2 compared as signed, and for SLTU when op1 < op2 compared as unsigned, and 0 otherwise; the value SHALL be zero-extended to WIDTH.
REQ-020 SHALL treat unused opcodes 11 to 15 as ADD.
REQ-021 SHALL compute MUL by iterative shift-add (one op2 bit per cycle) in EXEC, with a counter running 0 to WIDTH-1 and busy high throughout; after WIDTH cycles in EXEC the FSM SHALL move to DONE.
REQ-022 SHALL return the low WIDTH bits of the unsigned product for MUL, with out_valid high exactly WIDTH+1 cycles after acceptance.
REQ-023 SHALL hold result and out_valid stable in DONE while out_ready is low.
REQ-024 SHALL, in DONE with out_ready high and no new acceptance, clear out_valid and go to IDLE.
REQ-025 SHALL, on simultaneous result consumption and new acceptance in DONE, load the new operation without a bubble.
REQ-026 SHALL ignore in_valid while in EXEC, since in_ready is low there.

Reset
REQ-027 SHALL, while rst_n is low, immediately force the state to IDLE, result to 0, out_valid to 0, busy to 0, and the counter and multiplier registers to 0.
REQ-028 SHALL abort any in-flight operation on reset with no result delivered; after reset release, in_ready SHALL be 1 on the first clock edge.

Configuration
REQ-029 SHALL compile in the iterative multiplier when macro ALU_MC_MUL_EN is defined, giving MUL the behaviour in REQ-021 and REQ-022.
REQ-030 SHALL, when ALU_MC_MUL_EN is undefined, omit the multiplier and counter logic, treat opcode 10 as ADD with 1-cycle latency, hold busy at 0, and never enter EXEC.

Verification
REQ-031 SHALL cover ADD: WIDTH=32, op1=5, op2=7 -> result 12, out_valid on the cycle after acceptance.
REQ-032 SHALL cover SUB wrap and compares: SUB 0-1 -> 0xFFFFFFFF; SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0; SRA 0x80000000 by op2=0x21 -> 0xC0000000.
REQ-033 SHALL cover MUL with macro on: 0x0001_0003 x 0x0000_0010 -> 0x0010_0030, out_valid exactly 33 cycles after acceptance, busy high for 32 cycles; with macro off the same stimulus -> 0x0001_0013 after 1 cycle.
REQ-034 SHALL cover backpressure: out_ready low for 5 cycles after AND 0xF0F0,0xFF00 -> result 0xF000 held stable, in_ready low, then one handshake.
REQ-035 SHALL cover back-to-back: out_ready=1 and in_valid=1 with ops ADD 1,1 then XOR 3,1 -> results 2 then 2 on consecutive cycles, with no idle gap.
REQ-036 SHALL cover reset mid-MUL: rst_n low at EXEC cycle 10 -> out_valid=0, busy=0, result=0; after release, ADD 2,2 -> 4.
